// File: rtl/npc_seq_ctrl_if.sv
// npc_seq_ctrl_if: fetch/LSU handshakes, decode flags and
// sequencer strobes between the controller and the core datapath.
interface npc_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ifu_req_valid;
    logic             ifu_req_ready;
    logic             ifu_resp_valid;
    logic             ifu_resp_ready;
    logic             inst_latch_en;
    logic             dec_read_mem;
    logic             dec_write_mem;
    logic             dec_rd_en;
    logic             dec_ebreak;
    logic             lsu_req_valid;
    logic             lsu_req_we;
    logic             lsu_req_ready;
    logic             lsu_resp_valid;
    logic             lsu_resp_ready;
    logic             rf_we;
    logic             pc_we;
    logic             halt;
    logic             bus_err;
    logic [CNT_W-1:0] inst_cnt;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_resp_valid,
        output ifu_resp_ready,
        output inst_latch_en,
        input  dec_read_mem,
        input  dec_write_mem,
        input  dec_rd_en,
        input  dec_ebreak,
        output lsu_req_valid,
        output lsu_req_we,
        input  lsu_req_ready,
        input  lsu_resp_valid,
        output lsu_resp_ready,
        output rf_we,
        output pc_we,
        output halt,
        output bus_err,
        output inst_cnt
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_resp_valid,
        input  ifu_resp_ready,
        input  inst_latch_en,
        output dec_read_mem,
        output dec_write_mem,
        output dec_rd_en,
        output dec_ebreak,
        input  lsu_req_valid,
        input  lsu_req_we,
        output lsu_req_ready,
        output lsu_resp_valid,
        input  lsu_resp_ready,
        input  rf_we,
        input  pc_we,
        input  halt,
        input  bus_err,
        input  inst_cnt
    );
endinterface

// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle FETCH/EXEC/MEM/WB sequencer for npc.
// Optional bus-wait timeout enabled by defining NPC_BUS_TIMEOUT_EN.
module npc_seq_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic           clk,
    input logic           rst,
    npc_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH, IWAIT, EXEC, MREQ, MWAIT, WB, HALT
    } state_t;

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             ifu_req_q, ifu_rsp_q;
    logic             lsu_req_q, lsu_rsp_q;
    logic             pc_we_q, halt_q;
    logic             bus_err_q;
    logic             tmo_hit;

`ifdef NPC_BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             wait_st;
`else
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        nxt     = state;
        tmo_hit = 1'b0;
        unique case (state)
            FETCH: if (bus.ifu_req_ready) nxt = IWAIT;
            IWAIT: if (bus.ifu_resp_valid) nxt = EXEC;
            EXEC: begin
                if (bus.dec_ebreak)
                    nxt = HALT;
                else if (bus.dec_read_mem || bus.dec_write_mem)
                    nxt = MREQ;
                else
                    nxt = WB;
            end
            MREQ:  if (bus.lsu_req_ready) nxt = MWAIT;
            MWAIT: if (bus.lsu_resp_valid) nxt = WB;
            WB:    nxt = FETCH;
            HALT:  nxt = HALT;
            default: nxt = FETCH;
        endcase
`ifdef NPC_BUS_TIMEOUT_EN
        // handshake is resolved first, so it wins over the limit
        wait_st = (state == FETCH) || (state == IWAIT) ||
                  (state == MREQ)  || (state == MWAIT);
        if (wait_st && nxt == state && tmo_q == TMO_LAST) begin
            nxt     = HALT;
            tmo_hit = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            cnt_q     <= '0;
            ifu_req_q <= 1'b1;
            ifu_rsp_q <= 1'b0;
            lsu_req_q <= 1'b0;
            lsu_rsp_q <= 1'b0;
            pc_we_q   <= 1'b0;
            halt_q    <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef NPC_BUS_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state     <= nxt;
            ifu_req_q <= (nxt == FETCH);
            ifu_rsp_q <= (nxt == IWAIT);
            lsu_req_q <= (nxt == MREQ);
            lsu_rsp_q <= (nxt == MWAIT);
            pc_we_q   <= (nxt == WB);
            halt_q    <= (nxt == HALT);
            if (state == WB)
                cnt_q <= cnt_q + CNT_W'(1);
            if (tmo_hit)
                bus_err_q <= 1'b1;
`ifdef NPC_BUS_TIMEOUT_EN
            if (nxt != state)
                tmo_q <= '0;
            else if (wait_st)
                tmo_q <= tmo_q + TMO_W'(1);
`endif
        end
    end

    assign bus.ifu_req_valid  = ifu_req_q;
    assign bus.ifu_resp_ready = ifu_rsp_q;
    assign bus.inst_latch_en  = ifu_rsp_q & bus.ifu_resp_valid;
    assign bus.lsu_req_valid  = lsu_req_q;
    assign bus.lsu_req_we     = lsu_req_q & bus.dec_write_mem;
    assign bus.lsu_resp_ready = lsu_rsp_q;
    assign bus.pc_we          = pc_we_q;
    assign bus.rf_we          = pc_we_q & bus.dec_rd_en &
                                ~bus.dec_write_mem;
    assign bus.halt           = halt_q;
    assign bus.inst_cnt       = cnt_q;
`ifdef NPC_BUS_TIMEOUT_EN
    assign bus.bus_err        = bus_err_q;
`else
    assign bus.bus_err        = 1'b0;
    logic unused_err;
    assign unused_err = bus_err_q | tmo_hit;
`endif
endmodule
